// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder.
// State encoding and width limits.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } sa_state_t;

    localparam int MAX_WIDTH = 32;

endpackage

// File: rtl/fulladder.sv
// One-bit full adder cell used by the lab datapath.
// Purely combinational.
module fulladder (
    input  logic ain,
    input  logic bin,
    input  logic cin,
    output logic sout,
    output logic cout
);

    assign sout = ain ^ bin ^ cin;
    assign cout = (ain & bin) | (cin & (ain ^ bin));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one fulladder cell stepped LSB-first.
// WIDTH cycles per add, plus one DONE cycle.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    sa_state_t        state;
    sa_state_t        state_n;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_c;
    logic             last;

    fulladder u_fa (
        .ain  (a_sh[0]),
        .bin  (b_sh[0]),
        .cin  (carry),
        .sout (fa_s),
        .cout (fa_c)
    );

    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (start) state_n = RUN;
            RUN:  if (last)  state_n = DONE;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        ready = (state == IDLE);
        done  = (state == DONE);
    end

    // Result regs hold the last answer through IDLE until a new accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        sum   <= '0;
                    end
                end
                RUN: begin
                    sum   <= {fa_s, sum[WIDTH-1:1]};
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= fa_c;
                    if (!last) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cout <= fa_c;
                        ovf  <= carry ^ fa_c;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8.
// Scoreboard queue plus a vector table and corner sequences.
module tb_serial_adder;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         ready;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int   checks = 0;
    int   errors = 0;
    int   ndone  = 0;
    exp_t sb[$];
    vec_t vecs[7];

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .ready (ready),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && done) begin
            exp_t e;
            ndone++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending result");
            end else begin
                e = sb.pop_front();
                chk("sum", 32'(sum), 32'(e.s));
                chk("cout", 32'(cout), 32'(e.co));
                chk("ovf", 32'(ovf), 32'(e.ov));
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 32'(ready), 32'd1);
    endtask

    task automatic accept(input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic vc, input logic [W-1:0] s,
                          input logic co, input logic ov);
        exp_t e;
        wait_ready();
        a     = va;
        b     = vb;
        cin   = vc;
        start = 1'b1;
        e.s   = s;
        e.co  = co;
        e.ov  = ov;
        sb.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic vc, input logic [W-1:0] s,
                          input logic co, input logic ov);
        int lat;
        accept(va, vb, vc, s, co, ov);
        wait_done(lat);
        chk("latency", 32'(lat), 32'd8);
        @(posedge clk);
        #1;
        chk("ready_after_done", 32'(ready), 32'd1);
        chk("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int d0;
        int prev;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};
        vecs[4] = '{8'hF0, 8'hF0, 1'b0, 8'hE0, 1'b1, 1'b0};
        vecs[5] = '{8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1};
        vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].ci,
                   vecs[i].s, vecs[i].co, vecs[i].ov);
        end

        // start pulses during RUN must be ignored
        d0 = ndone;
        accept(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'hFF;
        repeat (3) @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat);
        chk("busy_latency", 32'(lat), 32'd3);
        repeat (12) @(posedge clk);
        #1;
        chk("busy_one_done", 32'(ndone - d0), 32'd1);
        chk("busy_ready", 32'(ready), 32'd1);

        // reset in the middle of RUN
        accept(8'h55, 8'h11, 1'b0, 8'h66, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        chk("mid_rst_ready", 32'(ready), 32'd1);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_sum", 32'(sum), 32'd0);
        chk("mid_rst_cout", 32'(cout), 32'd0);
        chk("mid_rst_ovf", 32'(ovf), 32'd0);
        reset = 1'b0;
        run_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

        // start held high: one result every WIDTH+2 cycles
        wait_ready();
        d0    = ndone;
        a     = 8'h80;
        b     = 8'h80;
        cin   = 1'b0;
        start = 1'b1;
        sb.push_back('{8'h00, 1'b1, 1'b1});
        prev = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (done) begin
                if (prev >= 0) chk("b2b_period", 32'(i - prev), 32'd10);
                prev = i;
            end
            if (i == 30) start = 1'b0;
            else if (ready) sb.push_back('{8'h00, 1'b1, 1'b1});
        end
        repeat (3) @(negedge clk);
        chk("b2b_dones", 32'(ndone - d0), 32'd3);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial two's-complement adder that drives the team's existing `fulladder` one bit per clock.
- LSB-first shift registers feed `ain`/`bin`; a carry flip-flop feeds `cin` and captures `cout`; `sout` is shifted into the result register.
- Trades WIDTH cycles of latency for a single full-adder cell. This is the sequential stage wrapped around the ripple cell in the lab datapath.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a new addition; sampled only when ready=1.
- a  input  WIDTH  operand A; captured on the accepted-start edge.
- b  input  WIDTH  operand B; captured on the accepted-start edge.
- cin  input  1  carry-in; captured on the accepted-start edge.
- ready  output  1  high only in IDLE.
- done  output  1  one-cycle pulse when the result is valid.
- sum  output  WIDTH  result register.
- cout  output  1  final carry-out.
- ovf  output  1  signed overflow.

Behaviour:
- Reset (reset=1 at an edge, in any state, including mid-RUN):
  - state goes to IDLE, ready=1, done=0, sum=0, cout=0, ovf=0.
  - Shift registers, carry flip-flop and counter are cleared.
  - Reset has priority over start.
- State machine: IDLE, RUN, DONE.
- IDLE:
  - ready=1.
  - On an edge with start=1: a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, go to RUN.
  - sum, cout and ovf keep the previous result until the next start is accepted.
  - On accept, sum is cleared to 0.
- RUN (ready=0): the fulladder inputs are ain=a_sh[0], bin=b_sh[0], cin=carry. Each edge:
  - sum <= {sout, sum[WIDTH-1:1]}
  - a_sh and b_sh logical-shift right by 1
  - carry <= cout_fa
  - cnt <= cnt+1
  - When cnt==WIDTH-1 on that edge:
    - cout <= cout_fa
    - ovf <= carry ^ cout_fa (carry into the MSB xor carry out of the MSB)
    - go to DONE.
- DONE: done=1 and ready=0 for exactly one cycle; next edge goes to IDLE unconditionally.
- Latency: start accepted at edge E0; bits are processed on edges E1..E_WIDTH; done is high between E_WIDTH and E_WIDTH+1. Throughput is one result per WIDTH+2 cycles.
- start while RUN or DONE is ignored, not queued. Changing a, b or cin after acceptance has no effect.
- sum and cout are mid-shift and invalid during RUN. They are valid from the DONE cycle until the next accepted start.
- Arithmetic is modulo 2^WIDTH: {cout,sum} = a + b + cin (unsigned). ovf follows two's-complement rules.
- Counter width is $clog2(WIDTH). No wrap beyond WIDTH-1.

Decomposition:
- Package serial_adder_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} sa_state_t
  - localparam MAX_WIDTH = 32
- One sub-module: a single instance of the existing fulladder cell; no new sub-modules.
- Datapath (shift registers, carry flip-flop, counter) and FSM live in serial_adder.

Test Plan (WIDTH=8):
- Signed overflow: a=0x5A, b=0x3C, cin=0, start pulse → done exactly 8 cycles after the accept edge; sum=0x96, cout=0, ovf=1.
- Wrap to zero: a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, ovf=0; ready returns high the cycle after done.
- Carry-in to MSB: a=0x7F, b=0x00, cin=1 → sum=0x80, cout=0, ovf=1.
- start ignored while busy: accept a=0x10, b=0x20, then assert start with a=0xFF, b=0xFF during cycles 3..5 of RUN → result sum=0x30, cout=0; only one done pulse.
- Reset mid-operation: assert reset on RUN cycle 4 → next cycle ready=1, done=0, sum=0, cout=0, ovf=0. A new start with a=0x01, b=0x02 then yields sum=0x03.
- Back-to-back: hold start high continuously with a=0x80, b=0x80 → done pulses every 10 cycles; each result is sum=0x00, cout=1, ovf=1.
